// File: rtl/re_butterfly_pipe_if.sv
// Stream bundle for the first DCT/IDCT butterfly stage: input beat with sideband,
// output beat with sideband, and the valid/ready pair for each direction.
interface re_butterfly_pipe_if #(
  parameter int LANES = 32,
  parameter int IN_W  = 19,
  parameter int OUT_W = 20
);
  logic                   i_flush;
  logic                   i_valid;
  logic                   o_ready_in;
  logic                   i_inverse;
  logic [1:0]             i_tq_sel;
  logic [1:0]             i_transize;
  logic                   i_last;
  logic [LANES*IN_W-1:0]  i_data;
  logic                   o_valid;
  logic                   i_ready;
  logic                   o_inverse;
  logic [1:0]             o_tq_sel;
  logic [1:0]             o_transize;
  logic                   o_last;
  logic                   o_err;
  logic [LANES*OUT_W-1:0] o_data;

  modport slave (
    input  i_flush, i_valid, i_inverse, i_tq_sel, i_transize, i_last, i_data, i_ready,
    output o_ready_in, o_valid, o_inverse, o_tq_sel, o_transize, o_last, o_err, o_data
  );

  modport master (
    output i_flush, i_valid, i_inverse, i_tq_sel, i_transize, i_last, i_data, i_ready,
    input  o_ready_in, o_valid, o_inverse, o_tq_sel, o_transize, o_last, o_err, o_data
  );
endinterface

// File: rtl/re_butterfly_pipe.sv
// Elastic even/odd butterfly stage: combinational split/recombine per row segment,
// followed by a PIPE_DEPTH-deep bubble-collapsing register pipeline.
module re_butterfly_pipe #(
  parameter int LANES      = 32,
  parameter int IN_W       = 19,
  parameter int OUT_W      = 20,
  parameter int PIPE_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  re_butterfly_pipe_if.slave bus
);
  localparam int D_W  = LANES * OUT_W;
  localparam int SB_W = 7;

  logic signed [OUT_W-1:0] w_x  [LANES];
  logic signed [OUT_W-1:0] w_bf [4][LANES];
  logic [D_W-1:0]          w_res;
  logic                    w_err;
  logic                    w_bypass;
  logic [PIPE_DEPTH-1:0]   w_acc;

  logic [PIPE_DEPTH-1:0]           r_vld;
  logic [PIPE_DEPTH-1:0][D_W-1:0]  r_data;
  logic [PIPE_DEPTH-1:0][SB_W-1:0] r_sb;

  for (genvar k = 0; k < LANES; k++) begin : g_ext
    assign w_x[k] = OUT_W'($signed(bus.i_data[k*IN_W +: IN_W]));
  end

  // One butterfly network per transform size; the live one is picked by i_transize.
  for (genvar z = 0; z < 4; z++) begin : g_sz
    localparam int S = 4 << z;
    if (S > LANES) begin : g_none
      for (genvar k = 0; k < LANES; k++) begin : g_pass
        assign w_bf[z][k] = w_x[k];
      end
    end else begin : g_bf
      for (genvar m = 0; m < LANES / S; m++) begin : g_seg
        for (genvar j = 0; j < S / 2; j++) begin : g_pair
          localparam int B = m * S;
          assign w_bf[z][B+j] = bus.i_inverse ? (w_x[B+j] + w_x[B+S/2+j])
                                              : (w_x[B+j] + w_x[B+S-1-j]);
          assign w_bf[z][B+S/2+j] = bus.i_inverse ? (w_x[B+S/2-1-j] - w_x[B+S-1-j])
                                                  : (w_x[B+j] - w_x[B+S-1-j]);
        end
      end
    end
  end

  // Size check against the lane count and luma DST 4x4 bypass decision.
  always_comb begin
    w_err = 1'b0;
    case (bus.i_transize)
      2'd0:    w_err = (LANES < 32'sd4);
      2'd1:    w_err = (LANES < 32'sd8);
      2'd2:    w_err = (LANES < 32'sd16);
      2'd3:    w_err = (LANES < 32'sd32);
      default: w_err = 1'b1;
    endcase
    w_bypass = w_err || ((bus.i_transize == 2'd0) && !bus.i_tq_sel[1]);
  end

  // Output lane select between sign-extended input and the chosen network.
  always_comb begin
    w_res = '0;
    for (int k = 0; k < LANES; k++) begin
      if (w_bypass) begin
        w_res[k*OUT_W +: OUT_W] = w_x[k];
      end else begin
        w_res[k*OUT_W +: OUT_W] = w_bf[bus.i_transize][k];
      end
    end
  end

  // A stage can accept when it or any later stage has a hole, or the sink takes a beat.
  always_comb begin
    logic w_tail_full;
    w_tail_full = 1'b1;
    w_acc       = '0;
    for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
      w_tail_full = w_tail_full & r_vld[i];
      w_acc[i]    = !w_tail_full || bus.i_ready;
    end
  end

  // Pipeline registers; flush drops every in-flight beat and the one being presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_data <= '0;
      r_sb   <= '0;
    end else if (bus.i_flush) begin
      r_vld <= '0;
    end else begin
      if (w_acc[0]) begin
        r_vld[0] <= bus.i_valid;
        if (bus.i_valid) begin
          r_data[0] <= w_res;
          r_sb[0]   <= {bus.i_inverse, bus.i_tq_sel, bus.i_transize, bus.i_last, w_err};
        end
      end
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        if (w_acc[i]) begin
          r_vld[i] <= r_vld[i-1];
          if (r_vld[i-1]) begin
            r_data[i] <= r_data[i-1];
            r_sb[i]   <= r_sb[i-1];
          end
        end
      end
    end
  end

  assign bus.o_ready_in = w_acc[0];
  assign bus.o_valid    = r_vld[PIPE_DEPTH-1];
  assign bus.o_data     = r_data[PIPE_DEPTH-1];
  assign {bus.o_inverse, bus.o_tq_sel, bus.o_transize, bus.o_last, bus.o_err} = r_sb[PIPE_DEPTH-1];

endmodule

// File: tb/tb_re_butterfly_pipe.sv
// Randomised and directed bench for re_butterfly_pipe against a lane-level
// arithmetic model with an in-order scoreboard.
module tb_re_butterfly_pipe;
  localparam int LANES = 32;
  localparam int IN_W  = 19;
  localparam int OUT_W = 20;
  localparam int DEPTH = 2;
  localparam int D_W   = LANES * OUT_W;
  localparam int X_W   = LANES * IN_W;

  typedef struct packed {
    logic [D_W-1:0] d;
    logic [6:0]     sb;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  re_butterfly_pipe_if #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  re_butterfly_pipe #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .PIPE_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_out    = 0;
  beat_t exp_q[$];

  task automatic check_eq(input string tag, input logic [D_W-1:0] got, input logic [D_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: direct lane equations over integers, segment by segment.
  function automatic beat_t model(input logic inv, input logic [1:0] tq, input logic [1:0] tsz,
                                  input logic last, input logic [X_W-1:0] d);
    int    s;
    int    x[LANES];
    int    y[LANES];
    logic  err;
    beat_t b;
    s = 4 << tsz;
    for (int k = 0; k < LANES; k++) begin
      x[k] = $signed(d[k*IN_W +: IN_W]);
      y[k] = x[k];
    end
    err = (s > LANES);
    if (!err && !(s == 4 && !tq[1])) begin
      for (int base = 0; base < LANES; base += s) begin
        for (int j = 0; j < s / 2; j++) begin
          if (!inv) begin
            y[base+j]       = x[base+j] + x[base+s-1-j];
            y[base+s/2+j]   = x[base+j] - x[base+s-1-j];
          end else begin
            y[base+j]       = x[base+j] + x[base+s/2+j];
            y[base+s-1-j]   = x[base+j] - x[base+s/2+j];
          end
        end
      end
    end
    for (int k = 0; k < LANES; k++) b.d[k*OUT_W +: OUT_W] = y[k][OUT_W-1:0];
    b.sb = {inv, tq, tsz, last, err};
    return b;
  endfunction

  function automatic logic [X_W-1:0] rand_data();
    logic [X_W-1:0] d;
    logic [31:0]    r;
    for (int k = 0; k < LANES; k++) begin
      r = $urandom();
      d[k*IN_W +: IN_W] = r[IN_W-1:0];
    end
    return d;
  endfunction

  function automatic logic [X_W-1:0] seg4_in(input int a, input int b, input int c, input int e);
    logic [X_W-1:0] d;
    int v;
    for (int k = 0; k < LANES; k++) begin
      v = (k % 4 == 0) ? a : (k % 4 == 1) ? b : (k % 4 == 2) ? c : e;
      d[k*IN_W +: IN_W] = v[IN_W-1:0];
    end
    return d;
  endfunction

  function automatic logic [D_W-1:0] seg4_out(input int a, input int b, input int c, input int e);
    logic [D_W-1:0] d;
    int v;
    for (int k = 0; k < LANES; k++) begin
      v = (k % 4 == 0) ? a : (k % 4 == 1) ? b : (k % 4 == 2) ? c : e;
      d[k*OUT_W +: OUT_W] = v[OUT_W-1:0];
    end
    return d;
  endfunction

  // Scoreboard, capacity and output-stability monitor, sampled mid-cycle.
  logic [D_W-1:0] prev_data;
  logic [6:0]     prev_sb;
  logic           prev_stall = 1'b0;
  logic [6:0]     sb_now;
  beat_t          e;
  always @(negedge clk) begin
    sb_now = {bus.o_inverse, bus.o_tq_sel, bus.o_transize, bus.o_last, bus.o_err};
    if (!rst_n || bus.i_flush) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_data", bus.o_data, prev_data);
        check_eq("stall_sb", sb_now, prev_sb);
      end
      if (bus.o_valid && bus.i_ready) begin
        n_out++;
        check_eq("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("out_data", bus.o_data, e.d);
          check_eq("out_sb", sb_now, e.sb);
        end
      end
      if (bus.i_valid && bus.o_ready_in)
        exp_q.push_back(model(bus.i_inverse, bus.i_tq_sel, bus.i_transize, bus.i_last, bus.i_data));
      check_eq("capacity", exp_q.size() <= DEPTH, 1'b1);
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_data  = bus.o_data;
      prev_sb    = sb_now;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic inv, input logic [1:0] tq, input logic [1:0] tsz,
                       input logic last, input logic [X_W-1:0] d);
    bus.i_valid    = v;
    bus.i_inverse  = inv;
    bus.i_tq_sel   = tq;
    bus.i_transize = tsz;
    bus.i_last     = last;
    bus.i_data     = d;
  endtask

  // Single beat into an empty pipe with i_ready high; checks the fixed latency.
  task automatic send_one(input logic inv, input logic [1:0] tq, input logic [1:0] tsz,
                          input logic [X_W-1:0] d, output logic [D_W-1:0] got, output logic err);
    int n;
    drive(1'b1, inv, tq, tsz, 1'b1, d);
    tick();
    bus.i_valid = 1'b0;
    n = 0;
    got = '0;
    err = 1'b0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (bus.o_valid) break;
    end
    check_eq("latency", n, DEPTH);
    got = bus.o_data;
    err = bus.o_err;
    tick();
  endtask

  logic [D_W-1:0] got;
  logic [D_W-1:0] expv;
  logic [X_W-1:0] xin;
  logic [X_W-1:0] xrt;
  logic [X_W-1:0] beats[6];
  logic           err;
  logic           acc;
  int             v;
  int             bi;
  int             out0;

  initial begin
    drive(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, '0);
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check_eq("rst_valid", bus.o_valid, 1'b0);
    check_eq("rst_data", bus.o_data, '0);
    check_eq("rst_sb", {bus.o_inverse, bus.o_tq_sel, bus.o_transize, bus.o_last, bus.o_err}, 7'd0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check_eq("rst_ready_in", bus.o_ready_in, 1'b1);
    tick();

    send_one(1'b0, 2'b10, 2'd0, seg4_in(1, 2, 3, 4), got, err);
    check_eq("t1_fwd4", got, seg4_out(5, 5, -3, -1));
    send_one(1'b1, 2'b11, 2'd0, seg4_in(5, 5, -3, -1), got, err);
    check_eq("t2_inv4", got, seg4_out(2, 4, 6, 8));

    for (int k = 0; k < LANES; k++) begin
      v = -262144;
      xin[k*IN_W +: IN_W] = v[IN_W-1:0];
      v = (k < 16) ? -524288 : 0;
      expv[k*OUT_W +: OUT_W] = v[OUT_W-1:0];
    end
    send_one(1'b0, 2'b10, 2'd3, xin, got, err);
    check_eq("t3_fwd32_min", got, expv);

    send_one(1'b0, 2'b00, 2'd0, seg4_in(7, -3, 0, 100), got, err);
    check_eq("t4_bypass", got, seg4_out(7, -3, 0, 100));
    check_eq("t4_err", err, 1'b0);

    // Round trip fwd then inv yields twice the input for every size.
    for (int z = 0; z < 4; z++) begin
      for (int k = 0; k < LANES; k++) begin
        v = int'($urandom_range(20000)) - 10000;
        xin[k*IN_W +: IN_W] = v[IN_W-1:0];
        v = 2 * v;
        expv[k*OUT_W +: OUT_W] = v[OUT_W-1:0];
      end
      send_one(1'b0, 2'b10, z[1:0], xin, got, err);
      for (int k = 0; k < LANES; k++) begin
        v = $signed(got[k*OUT_W +: OUT_W]);
        xrt[k*IN_W +: IN_W] = v[IN_W-1:0];
      end
      send_one(1'b1, 2'b10, z[1:0], xrt, got, err);
      check_eq("roundtrip", got, expv);
    end

    // Backpressure: six beats, sink stalled on cycles 2..6.
    for (int i = 0; i < 6; i++) beats[i] = rand_data();
    out0 = n_out;
    bi = 0;
    for (int c = 1; c <= 30; c++) begin
      bus.i_ready = !(c >= 2 && c <= 6);
      if (bi < 6) drive(1'b1, 1'b0, 2'b10, bi[1:0], bi == 5, beats[bi]);
      else bus.i_valid = 1'b0;
      @(negedge clk);
      if (c == 3) check_eq("t5_ready_low", bus.o_ready_in, 1'b0);
      if (c >= 7 && c <= 10) begin
        check_eq("t5_ready_back", bus.o_ready_in, 1'b1);
        check_eq("t5_out_valid", bus.o_valid, 1'b1);
      end
      acc = bus.i_valid && bus.o_ready_in;
      tick();
      if (acc) bi++;
    end
    check_eq("t5_count", n_out - out0, 32'd6);
    check_eq("t5_drained", exp_q.size(), 32'd0);

    // Random traffic with random backpressure.
    for (int c = 0; c < 600; c++) begin
      drive(($urandom() % 4) != 0, $urandom() % 2 == 1, 2'($urandom()), 2'($urandom()),
            $urandom() % 2 == 1, rand_data());
      bus.i_ready = ($urandom() % 4) != 0;
      tick();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    check_eq("rand_drained", exp_q.size(), 32'd0);

    // Flush with two beats held plus one presented in the flush cycle.
    bus.i_ready = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 2'd1, 1'b0, rand_data());
    tick();
    drive(1'b1, 1'b0, 2'b10, 2'd2, 1'b0, rand_data());
    tick();
    bus.i_flush = 1'b1;
    drive(1'b1, 1'b0, 2'b10, 2'd3, 1'b1, rand_data());
    tick();
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("t6_flush_quiet", bus.o_valid, 1'b0);
    end
    tick();

    // Reset with beats in flight.
    drive(1'b1, 1'b1, 2'b11, 2'd2, 1'b0, rand_data());
    tick();
    drive(1'b1, 1'b0, 2'b01, 2'd1, 1'b0, rand_data());
    tick();
    bus.i_valid = 1'b0;
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("t6_rst_quiet", bus.o_valid, 1'b0);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("t6_post_rst_quiet", bus.o_valid, 1'b0);
    end
    tick();
    send_one(1'b0, 2'b10, 2'd0, seg4_in(1, 2, 3, 4), got, err);
    check_eq("t6_recover", got, seg4_out(5, 5, -3, -1));
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
